// File: rtl/fsm_eg_multi_seg.sv
// fsm_eg_multi_seg: three-state control FSM with Mealy output y0 and Moore output yl
module fsm_eg_multi_seg (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic y0,
  output logic yl
);
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_t;
  state_t state, next;
  // state register; reset overrides every transition
  always_ff @(posedge clk) state <= reset ? S0 : next;
  // next-state and Mealy output; the encoding 2'b11 falls to default and recovers to S0
  always_comb begin
    next = state;
    y0 = 1'b0;
    case (state)
      S0: begin
        next = a ? (b ? S2 : S1) : S0;
        y0 = a & b;
      end
      S1: next = a ? S0 : S1;
      S2: next = S0;
      default: next = S0;
    endcase
  end
  // Moore output decoded from state alone
  always_comb yl = (state == S1) || (state == S2);
endmodule

// File: tb/tb_fsm_eg_multi_seg.sv
// tb_fsm_eg_multi_seg: directed and random stimulus checked against a behavioural model
module tb_fsm_eg_multi_seg;
  logic clk = 1'b0;
  logic reset, a, b, y0, yl;
  int vectors = 0;
  int miscompares = 0;
  int ms = 0;
  bit known = 1'b0;

  fsm_eg_multi_seg dut (.clk(clk), .reset(reset), .a(a), .b(b), .y0(y0), .yl(yl));

  always #10 clk = ~clk;

  function automatic int nxt(input int s, input logic ra, input logic rb);
    if (s == 0) return ra ? (rb ? 2 : 1) : 0;
    if (s == 1) return ra ? 0 : 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic ra, input logic rb, input logic rr);
    a = ra;
    b = rb;
    reset = rr;
    #1;
    if (known) check("y0_pre", y0, logic'(ms == 0 && ra && rb));
    @(posedge clk);
    if (rr) begin
      ms = 0;
      known = 1'b1;
    end else if (known) ms = nxt(ms, ra, rb);
    #1;
    if (known) begin
      check("yl", yl, logic'(ms == 1 || ms == 2));
      check("y0", y0, logic'(ms == 0 && ra && rb));
    end
  endtask

  initial begin
    a = 1'b0;
    b = 1'b0;
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'(i), 1'b0);
    a = 1'b1;
    b = 1'b0;
    #2 check("y0_mid_b0", y0, 1'b0);
    b = 1'b1;
    #2 check("y0_mid_b1", y0, 1'b1);
    check("yl_mid", yl, 1'b0);
    b = 1'b0;
    #2 check("y0_mid_b0b", y0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (300) step(1'($urandom), 1'($urandom), 1'($urandom_range(15) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fsm_eg_multi_seg.md
# fsm_eg_multi_seg

Small three-state control FSM driven by two qualifier inputs `a` and `b`. It produces one Mealy output `y0` and one Moore output `yl`. It is coded in multi-segment style: a state register, a next-state/Mealy combinational block, and a Moore output block. It is used as a reference control element and as a template for mixed Mealy/Moore FSMs in the design.

## Interface
- No parameters.
- `clk`    input   1  rising-edge clock; the only clock.
- `reset`  input   1  synchronous, active-high; sampled on the rising edge of `clk`.
- `a`      input   1  primary qualifier; synchronous to `clk`.
- `b`      input   1  secondary qualifier; only consulted in S0 when `a`=1.
- `y0`     output  1  Mealy output; combinational from state, `a` and `b`.
- `yl`     output  1  Moore output; decoded from state only.

## Operation
- State register is 2 bits, with encodings S0=2'b00, S1=2'b01, S2=2'b10.
- 2'b11 is illegal.
- Next-state and Mealy output rules:
  - S0, `a`=0 → S0, `y0`=0.
  - S0, `a`=1, `b`=1 → S2, `y0`=1.
  - S0, `a`=1, `b`=0 → S1, `y0`=0.
  - S1, `a`=1 → S0; `a`=0 → S1; `y0`=0.
  - S2 → S0 unconditionally; `y0`=0.
  - Illegal state 2'b11 → S0; `y0`=0, `yl`=0.
- Moore output: `yl`=1 in S1 and S2, 0 in S0 and the illegal state.
- `y0` is not registered. It follows `a`/`b` combinationally while in S0, with no clock delay.
- Reset:
  - On any rising edge with `reset`=1, state ← S0, overriding all transitions, including mid-sequence from S1 or S2.
  - `reset` does not gate `y0` combinationally. While reset is held after the first edge, state is S0, so `yl`=0 and `y0`=`a`&`b`.
- Before the first reset edge, the state is undefined. No output requirement applies in that window.
- Combinational blocks assign defaults (next=state, `y0`=0) so that no latches are inferred.

## Timing
- State update occurs on each rising edge of `clk`. `reset` has priority over the next-state logic.
- `yl` changes only after a clock edge, reflecting the new state in the same cycle.
- `y0` has zero-cycle latency from `a`/`b` within the current state.
- Path S0→S2→S0 takes 2 cycles per loop while `a`=`b`=1:
  - `y0` pulses high in the S0 cycles.
  - `yl` is high in the S2 cycles.
  - The two outputs are never high in the same cycle.
- S1 is left only on a cycle with `a`=1. The FSM dwells in S1 indefinitely while `a`=0.
- Reset asserted for 1 cycle is sufficient. Outputs reflect S0 from the edge after assertion.

## Test plan
- Held `a`=1, `b`=1, `reset`=1 for 1 edge then released (20 ns clock period):
  - After the reset edge: S0, `y0`=1, `yl`=0.
  - Next edge: S2, `y0`=0, `yl`=1.
  - Then alternates S0/S2 every cycle.
- From S0, `a`=1, `b`=0 for 1 edge → S1 (`yl`=1, `y0`=0). Hold `a`=0 for 3 edges → stays S1. Then `a`=1 for 1 edge → S0, `yl`=0.
- In S0, `a`=0 with `b` toggling over 4 cycles → state stays S0; `y0`=0 and `yl`=0 throughout.
- In S0, toggle `b` mid-cycle with `a`=1 and no clock edge → `y0` follows `b` immediately; state unchanged.
- Reset mid-operation:
  - Assert `reset` on the edge where the FSM is in S1 → S0 next cycle, `yl`=0.
  - Assert `reset` on the edge where the FSM is in S2 → S0 next cycle, `yl`=0.
- Force the state register to 2'b11 → `yl`=0, `y0`=0; next edge returns to S0.
